radix4_op_dispatcher: RTL and testbench
=======================================

RADIX4_OP_DISPATCHER -- requirements
Module: radix4_op_dispatcher

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, operand FIFO entries (power of 2, at least 2); MUL_LAT, default 4, cycles from the mul_start cycle to the mul_result sample cycle.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream operand pair valid.
REQ-005 in_ready  output  1  FIFO can accept; equals "FIFO not full".
REQ-006 in_a, in_b  input  4 each  unsigned multiplicand and multiplier.
REQ-007 mul_start  output  1  one-cycle start pulse to the radix-4 multiplier.
REQ-008 mul_a, mul_b  output  4 each  operands to the multiplier, registered.
REQ-009 mul_result  input  8  multiplier product.
REQ-010 mul_done  input  1  multiplier done flag; level, not a pulse; qualified only at the sample cycle.
REQ-011 out_valid  output  1  product available.
REQ-012 out_ready  input  1  downstream accepts the product.
REQ-013 out_product  output  8  captured product.
REQ-014 out_tag  output  2  issue sequence number, modulo 4.
REQ-015 err  output  1  sticky flag: mul_done was low at a sample cycle.

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high; the pair is pushed to the FIFO tail.
REQ-017 An output transfer SHALL occur when out_valid and out_ready are both high.
REQ-018 Data SHALL be held stable while valid is high and ready is low, on both the input and output handshakes.
REQ-019 The FSM SHALL have three states:
- IDLE to ISSUE when the FIFO is not empty and the output slot is free (out_valid low, or an output transfer occurs in this cycle).
- ISSUE lasts exactly one cycle: mul_start=1, mul_a/mul_b hold the popped head entry, then go to WAIT.
- WAIT counts MUL_LAT cycles, then goes to IDLE.
REQ-020 mul_result SHALL be captured at the end of the cycle MUL_LAT cycles after the ISSUE cycle. At that edge: out_product <= mul_result, out_valid <= 1, out_tag <= issue count, issue count increments modulo 4.
REQ-021 If mul_done is 0 at the capture edge, err SHALL set and stay set until reset; the product is still delivered.
REQ-022 mul_start SHALL never be high for two consecutive cycles, and SHALL never be high outside ISSUE.
REQ-023 Only one multiply SHALL be outstanding at a time.
REQ-024 Minimum issue-to-issue spacing SHALL be MUL_LAT+2 cycles.
REQ-025 A push and a pop in the same cycle SHALL both take effect, and the FIFO count SHALL be unchanged.
REQ-026 When the FIFO is full, in_ready SHALL be low even if a pop occurs in the same cycle (no pass-through).
REQ-027 FIFO pointers SHALL wrap modulo DEPTH. Full/empty SHALL be derived from a count register of width log2(DEPTH)+1.
REQ-028 Operands SHALL be unsigned. The product width SHALL be exactly 8 bits, with no truncation for inputs 0..15.

Reset
REQ-029 On rst=1 at a clock edge, the following SHALL reset:
- FSM to IDLE; FIFO count and pointers to 0; issue count to 0.
- mul_start=0, mul_a=0, mul_b=0.
- out_valid=0, out_product=0, out_tag=0, err=0.
- in_ready=1 from the first cycle after reset.
REQ-030 Reset asserted mid-operation (ISSUE or WAIT) SHALL discard the in-flight multiply and all FIFO contents, and no product SHALL be emitted afterwards. The multiplier SHALL share the same rst.

Structure
REQ-031 A shared package SHALL hold: MUL_LAT default, operand width 4, product width 8, tag width 2, and the FSM state encoding (IDLE, ISSUE, WAIT).
REQ-032 The operand FIFO SHALL be a separate sub-module, op_fifo, parameterised by DEPTH and data width 8 (the {a,b} pair). The FSM, latency counter and output register SHALL live in the top module.

Verification
REQ-033 Single op: push a=3, b=5 with out_ready=1. Required: mul_start high exactly one cycle; out_valid rises MUL_LAT+1 cycles after the push-to-issue; out_product=15, out_tag=0.
REQ-034 Extremes: push (15,15), (0,9), (15,1) back-to-back. Required: products 225, 0, 15 in order; tags 0, 1, 2; issue spacing of at least 6 cycles.
REQ-035 Backpressure: out_ready=0, push 6 pairs. Required:
- exactly 4 accepted into the FIFO plus 1 in flight (issued before the slot filled), as applicable to the timing;
- in_ready low when full;
- out_product held stable;
- after out_ready=1, all accepted products drain in order with no loss or duplication.
REQ-036 Mid-op reset: push (7,9), assert rst during WAIT. Required: no out_valid afterwards; all outputs at reset values; a following push of (2,6) yields 12 with tag 0.
REQ-037 Fault: a multiplier model holds mul_done=0 at the capture cycle for (4,4). Required: out_product=16 delivered and err=1, staying 1 through later good operations until rst.

Source files
------------

// File: rtl/radix4_op_dispatcher_pkg.sv
// Shared definitions for the radix-4 operand dispatcher.
// Holds the default multiplier latency, the operand/product/tag widths and the
// dispatcher FSM state encoding.
package radix4_op_dispatcher_pkg;

    localparam int MUL_LAT_DEF = 4;
    localparam int OP_W        = 4;
    localparam int PROD_W      = 8;
    localparam int TAG_W       = 2;
    localparam int PAIR_W      = 2 * OP_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/radix4_op_dispatcher_op_fifo.sv
// op_fifo: synchronous operand FIFO holding {a,b} pairs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, wdata_i write request and data (ignored while full)
//   pop_i           read request (ignored while empty)
//   rdata_o         head entry
//   empty_o, full_o occupancy flags derived from the count register
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/radix4_op_dispatcher.sv
// radix4_op_dispatcher: buffers operand pairs, issues them one at a time to an
// external fixed-latency radix-4 multiplier and holds each product in an
// output register until the downstream accepts it.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b  operand input handshake
//   mul_start/mul_a/mul_b        multiplier launch (registered operands)
//   mul_result/mul_done          multiplier product and done level
//   out_valid/out_ready          product output handshake
//   out_product/out_tag          captured product and issue number mod 4
//   err                          sticky: mul_done was low at a capture edge
//
// state    | meaning
// ST_IDLE  | waiting for a queued pair and a free output slot
// ST_ISSUE | mul_start high for one cycle, operands on mul_a/mul_b
// ST_WAIT  | counting MUL_LAT cycles; product captured on the last one
module radix4_op_dispatcher
    import radix4_op_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_result,
    input  logic              mul_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic [TAG_W-1:0]  out_tag,
    output logic              err
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [OP_W-1:0]     mul_a_q, mul_b_q;
    logic                out_valid_q;
    logic [PROD_W-1:0]   out_product_q;
    logic [TAG_W-1:0]    out_tag_q;
    logic [TAG_W-1:0]    issue_cnt_q;
    logic                err_q;

    logic                fifo_empty, fifo_full;
    logic [PAIR_W-1:0]   fifo_rdata;
    logic                issue_go;
    logic                capture;

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W)
    ) u_op_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .wdata_i ({in_a, in_b}),
        .pop_i   (issue_go),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // The output slot counts as free if it is being drained this very cycle.
    assign issue_go = (state_q == ST_IDLE) && !fifo_empty && (!out_valid_q || out_ready);
    assign capture  = (state_q == ST_WAIT) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (issue_go) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (cnt_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mul_start = 1'b0;
        if (state_q == ST_ISSUE) mul_start = 1'b1;
    end

    // Latency down-counter: loaded in ISSUE so WAIT lasts exactly MUL_LAT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
            issue_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            if (issue_go) begin
                mul_a_q <= fifo_rdata[PAIR_W-1:OP_W];
                mul_b_q <= fifo_rdata[OP_W-1:0];
            end

            if (state_q == ST_ISSUE)
                cnt_q <= CNT_W'(MUL_LAT - 1);
            else if ((state_q == ST_WAIT) && (cnt_q != '0))
                cnt_q <= cnt_q - 1'b1;

            // The slot is always empty during WAIT, so capture never collides
            // with a pending product.
            if (capture) begin
                out_valid_q   <= 1'b1;
                out_product_q <= mul_result;
                out_tag_q     <= issue_cnt_q;
                issue_cnt_q   <= issue_cnt_q + 1'b1;
                if (!mul_done) err_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready    = !fifo_full;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_tag     = out_tag_q;
    assign err         = err_q;

endmodule

// File: tb/tb_radix4_op_dispatcher.sv
module tb_radix4_op_dispatcher;

    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b;
    logic       mul_start;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_result;
    logic       mul_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_product;
    logic [1:0] out_tag;
    logic       err;

    radix4_op_dispatcher #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_result  (mul_result),
        .mul_done    (mul_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Multiplier stand-in: product only valid in the exact sample cycle,
    // done is a level that stays high afterwards unless a fault is injected.
    int         m_phase;
    bit         m_act;
    bit         m_fault;
    bit         fault_next;
    logic [7:0] m_mprod;

    always @(posedge clk) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_phase <= -1;
            m_fault <= 1'b0;
            m_mprod <= 8'd0;
        end else if (mul_start) begin
            m_act   <= 1'b1;
            m_phase <= MUL_LAT - 1;
            m_mprod <= 8'(int'(mul_a) * int'(mul_b));
            m_fault <= fault_next;
        end else if (m_phase >= 0) begin
            m_phase <= m_phase - 1;
        end
    end

    assign mul_done   = m_act && (m_phase <= 0) && !m_fault;
    assign mul_result = (m_act && (m_phase == 0)) ? m_mprod : 8'hAA;

    // Reference model: queue of accepted pairs, timestamp of the current issue,
    // and the output slot, advanced once per cycle from that cycle's inputs.
    logic [7:0] m_q[$];
    logic [7:0] m_cur, m_last, m_prod;
    logic [1:0] m_tag;
    bit         m_ov, m_err, m_inflight;
    int         m_cnt, m_issue_cyc;
    int         cyc = 0;
    bit         chk_en = 0;
    bit         cap, go, xfer, full_now;
    bit         ov_prev = 0;

    logic [9:0] outlog[$];
    int         starts[$];
    int         rises[$];

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("in_ready",    32'(in_ready),    32'(m_q.size() < DEPTH));
            chk("mul_start",   32'(mul_start),   32'(m_inflight && (cyc == m_issue_cyc)));
            chk("mul_a",       32'(mul_a),       32'(m_last[7:4]));
            chk("mul_b",       32'(mul_b),       32'(m_last[3:0]));
            chk("out_valid",   32'(out_valid),   32'(m_ov));
            chk("out_product", 32'(out_product), 32'(m_prod));
            chk("out_tag",     32'(out_tag),     32'(m_tag));
            chk("err",         32'(err),         32'(m_err));
            if (mul_start) starts.push_back(cyc);
            if (out_valid && !ov_prev) rises.push_back(cyc);
            if (out_valid && out_ready && !rst) outlog.push_back({out_tag, out_product});
        end
        ov_prev = out_valid;

        if (rst) begin
            m_q.delete();
            m_ov = 0; m_err = 0; m_inflight = 0;
            m_prod = 8'd0; m_tag = 2'd0; m_last = 8'd0; m_cur = 8'd0;
            m_cnt = 0; m_issue_cyc = -100;
            chk_en = 1;
        end else begin
            cap      = m_inflight && (cyc == m_issue_cyc + MUL_LAT);
            xfer     = m_ov && out_ready;
            full_now = (m_q.size() >= DEPTH);
            go       = !m_inflight && (m_q.size() > 0) && (!m_ov || out_ready);
            if (cap) begin
                m_ov   = 1;
                m_prod = 8'(int'(m_cur[7:4]) * int'(m_cur[3:0]));
                m_tag  = 2'(m_cnt);
                m_cnt++;
                if (!mul_done) m_err = 1;
                m_inflight = 0;
            end else if (xfer) begin
                m_ov = 0;
            end
            if (go) begin
                m_cur       = m_q.pop_front();
                m_last      = m_cur;
                m_inflight  = 1;
                m_issue_cyc = cyc + 1;
            end
            if (in_valid && !full_now) m_q.push_back({in_a, in_b});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; in_valid = 0;
        step(2);
        rst = 0;
        outlog.delete(); starts.delete(); rises.delete();
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input int bound, output bit ok);
        in_valid = 1; in_a = a; in_b = b; ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                step(1);
                break;
            end
            step(1);
        end
        in_valid = 0;
    endtask

    task automatic wait_start(output bit found);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mul_start) begin
                found = 1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < outlog.size()) return 32'(outlog[i]);
        return 32'hFFFF;
    endfunction

    bit ok;

    initial begin
        rst = 1; in_valid = 0; in_a = 0; in_b = 0; out_ready = 1; fault_next = 0;
        step(3);
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err",       32'(err),       32'd0);
        step(1);

        // Single op: 3*5
        do_reset();
        push(4'd3, 4'd5, 5, ok);
        chk("t1_accept", 32'(ok), 32'd1);
        step(12);
        chk("t1_nstart", 32'(starts.size()), 32'd1);
        chk("t1_nout",   32'(outlog.size()), 32'd1);
        chk("t1_out0",   log_at(0), 32'({2'd0, 8'd15}));
        if (starts.size() > 0 && rises.size() > 0)
            chk("t1_latency", 32'(rises[0] - starts[0]), 32'(MUL_LAT + 1));
        else
            chk("t1_latency_seen", 32'(rises.size()), 32'd1);

        // Extremes back-to-back
        do_reset();
        push(4'd15, 4'd15, 5, ok);
        push(4'd0,  4'd9,  5, ok);
        push(4'd15, 4'd1,  5, ok);
        step(30);
        chk("t2_out0", log_at(0), 32'({2'd0, 8'd225}));
        chk("t2_out1", log_at(1), 32'({2'd1, 8'd0}));
        chk("t2_out2", log_at(2), 32'({2'd2, 8'd15}));
        chk("t2_nstart", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            chk("t2_space01", 32'(starts[1] - starts[0] >= MUL_LAT + 2), 32'd1);
            chk("t2_space12", 32'(starts[2] - starts[1] >= MUL_LAT + 2), 32'd1);
        end

        // Backpressure: 6 offered, 5 accepted (1 in flight + 4 queued)
        do_reset();
        out_ready = 0;
        begin
            int acc;
            acc = 0;
            for (int i = 1; i <= 6; i++) begin
                push(4'(2 * i - 1), 4'(2 * i), 20, ok);
                if (ok) acc++;
            end
            chk("t3_accepted", 32'(acc), 32'd5);
        end
        @(negedge clk);
        chk("t3_full_ready", 32'(in_ready),    32'd0);
        chk("t3_held_valid", 32'(out_valid),   32'd1);
        chk("t3_held_prod",  32'(out_product), 32'd2);
        step(1);
        out_ready = 1;
        step(45);
        chk("t3_nout", 32'(outlog.size()), 32'd5);
        chk("t3_out0", log_at(0), 32'({2'd0, 8'd2}));
        chk("t3_out1", log_at(1), 32'({2'd1, 8'd12}));
        chk("t3_out2", log_at(2), 32'({2'd2, 8'd30}));
        chk("t3_out3", log_at(3), 32'({2'd3, 8'd56}));
        chk("t3_out4", log_at(4), 32'({2'd0, 8'd90}));

        // Mid-operation reset during WAIT
        do_reset();
        push(4'd7, 4'd9, 5, ok);
        wait_start(ok);
        chk("t4_started", 32'(ok), 32'd1);
        step(1);
        rst = 1;
        step(1);
        rst = 0;
        outlog.delete();
        step(10);
        chk("t4_no_out",   32'(outlog.size()), 32'd0);
        chk("t4_valid",    32'(out_valid),     32'd0);
        chk("t4_product",  32'(out_product),   32'd0);
        chk("t4_mul_a",    32'(mul_a),         32'd0);
        push(4'd2, 4'd6, 5, ok);
        step(12);
        chk("t4_out0", log_at(0), 32'({2'd0, 8'd12}));

        // Fault: mul_done held low for (4,4)
        do_reset();
        fault_next = 1;
        push(4'd4, 4'd4, 5, ok);
        wait_start(ok);
        chk("t5_started", 32'(ok), 32'd1);
        step(1);
        fault_next = 0;
        step(10);
        chk("t5_out0", log_at(0), 32'({2'd0, 8'd16}));
        chk("t5_err",  32'(err), 32'd1);
        push(4'd2, 4'd3, 5, ok);
        step(12);
        chk("t5_out1",      log_at(1), 32'({2'd1, 8'd6}));
        chk("t5_err_stick", 32'(err), 32'd1);
        do_reset();
        @(negedge clk);
        chk("t5_err_clear", 32'(err), 32'd0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1);
    end

endmodule
